// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four DVI control tokens and the receive alignment state.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } link_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control-token match or data byte recovery.
// Every 10-bit code yields a defined byte; non-token codes are treated as data.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_ctrl
);

  logic [7:0] d_pre;

  always_comb begin
    d_pre = sym[9] ? ~sym[7:0] : sym[7:0];
    data  = '0;
    data[0] = d_pre[0];
    // bit 8 selects whether the transmitter chained with XOR or XNOR
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d_pre[i] ^ d_pre[i-1]) : ~(d_pre[i] ^ d_pre[i-1]);
    end

    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (sym)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default:       is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Per-channel TMDS receiver: bit-slip search on control-token runs, then symbol decode.
// Word sampled at edge t reaches the outputs at edge t+2; no backpressure, one word per cycle.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN     = 12,
  parameter int SLIP_TIMEOUT = 256,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked_out,
  output logic [3:0] bit_offset_out
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int SLIP_W = $clog2(SLIP_TIMEOUT);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = '1;
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  link_state_e       state_q;
  logic [9:0]        prev_q;
  logic [9:0]        sym_q;
  logic [3:0]        off_q;
  logic [RUN_W-1:0]  run_q;
  logic [SLIP_W-1:0] slip_q;
  logic [LOSS_W-1:0] loss_q;
  logic [1:0]        ign_q;
  logic [7:0]        data_q;
  logic [1:0]        ctrl_q;
  logic              de_q;
  logic              locked_q;

  logic [19:0] cat;
  logic [9:0]  win_d;
  logic [7:0]  dec_data;
  logic [1:0]  dec_ctrl;
  logic        dec_is_ctrl;
  logic        lock_hit;
  logic        loss_hit;
  logic        locked_d;

  // Older word in the low half so the window slides forward in arrival order.
  always_comb begin
    cat   = {tmds_in, prev_q};
    win_d = cat[9:0];
    for (int k = 1; k < 10; k++) begin
      if (off_q == 4'(k)) win_d = cat[k +: 10];
    end
  end

  tmds_symbol_decode u_symbol_decode (
    .sym     (sym_q),
    .data    (dec_data),
    .ctrl    (dec_ctrl),
    .is_ctrl (dec_is_ctrl)
  );

  assign lock_hit = (state_q == SEARCH) && (ign_q == 2'd0) && dec_is_ctrl && (run_q == RUN_LAST);
  assign loss_hit = (state_q == LOCKED) && !dec_is_ctrl && (loss_q == LOSS_LAST);
  assign locked_d = lock_hit || ((state_q == LOCKED) && !loss_hit);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      sym_q    <= '0;
      off_q    <= '0;
      run_q    <= '0;
      slip_q   <= '0;
      loss_q   <= '0;
      ign_q    <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= tmds_in;
      sym_q    <= win_d;
      locked_q <= locked_d;
      de_q     <= locked_d && !dec_is_ctrl;
      data_q   <= (locked_d && !dec_is_ctrl) ? dec_data : 8'd0;
      ctrl_q   <= (locked_d && dec_is_ctrl) ? dec_ctrl : 2'd0;

      case (state_q)
        SEARCH: begin
          if (lock_hit) begin
            state_q <= LOCKED;
            run_q   <= '0;
            slip_q  <= '0;
            loss_q  <= '0;
          end else if (slip_q == SLIP_LAST) begin
            // Two refill cycles: sym_q still holds the old offset, then the new one settles.
            off_q  <= (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
            slip_q <= '0;
            run_q  <= '0;
            ign_q  <= 2'd2;
          end else begin
            slip_q <= slip_q + SLIP_W'(1);
            if (ign_q != 2'd0) begin
              ign_q <= ign_q - 2'd1;
            end else if (dec_is_ctrl) begin
              run_q <= (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end else begin
              run_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (dec_is_ctrl) begin
            loss_q <= '0;
          end else if (loss_hit) begin
            state_q <= SEARCH;
            loss_q  <= '0;
            run_q   <= '0;
            slip_q  <= '0;
          end else begin
            loss_q <= loss_q + LOSS_W'(1);
          end
        end
      endcase
    end
  end

  assign data_out       = data_q;
  assign ctrl_out       = ctrl_q;
  assign de_out         = de_q;
  assign locked_out     = locked_q;
  assign bit_offset_out = off_q;

endmodule
